// File: rtl/block_ram.sv
// Single-port word-addressed block RAM, read-first, with registered read data.
// Define BLOCK_RAM_OUT_REG_EN to add a second output register (read latency 2).
module block_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] di,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Upper address bits are deliberately ignored so addresses alias modulo depth.
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_unused_addr_hi;

    assign w_addr           = addr[ADDR_WIDTH-1:0];
    assign w_unused_addr_hi = ^addr[31:ADDR_WIDTH];

    // Declaration initialiser gives the all-zero power-up contents (maps to BRAM init).
    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] r_rd_data;

    // NOTE: the array has no reset branch; resetting a memory prevents BRAM inference,
    // and reset here only suppresses the write rather than clearing contents.
    always_ff @(posedge clk) begin
        if (!rst && en && we) begin
            r_mem[w_addr] <= di;
        end
    end

    // NOTE: non-blocking read of r_mem samples the pre-write contents, giving read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (en) begin
            r_rd_data <= r_mem[w_addr];
        end
    end

`ifdef BLOCK_RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] r_out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_reg <= '0;
        end else if (en) begin
            r_out_reg <= r_rd_data;
        end
    end

    assign dout = r_out_reg;
`else
    assign dout = r_rd_data;
`endif

endmodule

// File: tb/tb_block_ram.sv
// Randomised bench for block_ram: an array/queue reference model checked every cycle,
// plus directed literal expectations that pin both the model and the DUT.
module tb_block_ram;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
`ifdef BLOCK_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          we  = 1'b0;
    logic [31:0]   addr = '0;
    logic [DW-1:0] di   = '0;
    logic [DW-1:0] dout;

    block_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .we   (we),
        .addr (addr),
        .di   (di),
        .dout (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] val;
        string       name;
    } lit_t;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    bit            checking = 1'b0;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] m_dout = '0;
    lit_t          lits [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_dout = '0;
        m_q.delete();
        for (int i = 0; i < LAT - 1; i++) m_q.push_back('0);
    endtask

    // One clock: drive at the falling edge, then apply the spec rules at the rising edge.
    task automatic step(input bit r, input bit e, input bit w, input logic [31:0] a,
                        input logic [DW-1:0] d);
        int idx;
        logic [DW-1:0] old;
        @(negedge clk);
        rst = r; en = e; we = w; addr = a; di = d;
        @(posedge clk);
        cyc++;
        idx = int'(a % DEPTH);
        if (r) begin
            model_reset();
        end else if (e) begin
            old = m_mem[idx];
            m_q.push_back(old);
            m_dout = m_q.pop_front();
            if (w) m_mem[idx] = d;
        end
    endtask

    // Expect dout == v once the value launched by the last step has crossed the read latency.
    task automatic expect_read(input logic [31:0] v, input string name);
        lits.push_back('{due: cyc + LAT - 1, val: v, name: name});
    endtask

    task automatic expect_now(input logic [31:0] v, input string name);
        lits.push_back('{due: cyc, val: v, name: name});
    endtask

    // Single compare process: model every cycle, plus any literal due this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                check("model", dout, m_dout);
                for (int i = lits.size() - 1; i >= 0; i--) begin
                    if (lits[i].due == cyc) begin
                        check({lits[i].name, "_dut"}, dout, lits[i].val);
                        check({lits[i].name, "_model"}, m_dout, lits[i].val);
                        lits.delete(i);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        model_reset();

        step(1, 1, 0, 0, 0);
        checking = 1'b1;
        expect_now(0, "reset_state");
        step(1, 1, 0, 0, 0);

        // Writes then back-to-back reads.
        step(0, 1, 1, 55, 23);
        step(0, 1, 1, 47, 1);
        step(0, 1, 1, 147, 1256);
        step(0, 1, 0, 55, 0);   expect_read(23, "rd55");
        step(0, 1, 0, 47, 0);   expect_read(1, "rd47");
        step(0, 1, 0, 147, 0);  expect_read(1256, "rd147");

        // Unwritten location, and di ignored when we=0.
        step(0, 1, 0, 46, 126); expect_read(0, "rd46_unwritten");
        step(0, 1, 0, 55, 0);   expect_read(23, "rd55_after_we0");

        // Read-during-write is read-first.
        step(0, 1, 1, 55, 99);  expect_read(23, "rdw_old");
        step(0, 1, 0, 55, 0);   expect_read(99, "rdw_new");
        repeat (LAT) step(0, 1, 0, 55, 0);

        // Disabled port holds and ignores the write; then alias read.
        step(0, 0, 1, 47, 5);   expect_now(99, "en0_hold");
        step(0, 1, 0, 47, 0);   expect_read(1, "rd47_after_en0");
        step(0, 1, 0, 1024 + 147, 0); expect_read(1256, "alias_1171");
        repeat (LAT) step(0, 1, 0, 1024 + 147, 0);

        // Reset with dout non-zero and a write pending.
        step(1, 1, 1, 55, 7);   expect_now(0, "rst_clears");
        step(1, 1, 1, 55, 7);   expect_now(0, "rst_second");
        step(0, 1, 0, 55, 0);   expect_read(99, "rst_no_write");
        repeat (LAT) step(0, 1, 0, 0, 0);

        // Randomised traffic over a small address pool with random upper bits.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) * 61 % DEPTH);
            if ($urandom_range(0, 7) == 0) a = $urandom();
            step($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 1) == 1, a, $urandom());
        end

        @(negedge clk);
        check("lits_drained", 32'(lits.size()), 0);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_ram.md
BLOCK_RAM -- requirements
Module: block_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of the data word for di, dout and storage.
REQ-002 Parameter ADDR_WIDTH, default 10, sets the number of address bits used; depth is 2**ADDR_WIDTH words (1024).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  port enable; gates both read and write.
REQ-006 we  input  1  write enable; effective only when en=1.
REQ-007 addr  input  32  word address (not byte address).
REQ-008 di  input  32  write data.
REQ-009 dout  output  32  registered read data.

Function
REQ-010 Storage SHALL be 2**ADDR_WIDTH words of DATA_WIDTH bits, word-addressed, with all words zero at power-up/simulation start.
REQ-011 Only addr[ADDR_WIDTH-1:0] SHALL be decoded; addr[31:ADDR_WIDTH] SHALL be ignored, so addresses alias modulo depth with no error.
REQ-012 Write: on a rising edge with rst=0, en=1 and we=1, mem[addr] SHALL be loaded with di.
REQ-013 Read: on a rising edge with rst=0 and en=1, dout SHALL be loaded with mem[addr]; read latency is 1 clock with the output stage of REQ-020 absent.
REQ-014 A read SHALL occur on every enabled edge regardless of we.
REQ-015 Read-during-write to the same address SHALL be read-first: dout gets the old contents and the new data is visible on the next read.
REQ-016 With en=0 and rst=0, memory and dout SHALL hold; we and di SHALL be ignored.
REQ-017 dout SHALL never be X after the first reset edge; unwritten locations read as 0.

Reset
REQ-018 On a rising edge with rst=1, dout and every output pipeline register SHALL be cleared to 0, independent of en.
REQ-019 rst SHALL NOT clear memory contents, and any write requested while rst=1 SHALL be suppressed; rst has priority over en and we.

Configuration
REQ-020 Macro BLOCK_RAM_OUT_REG_EN, when defined, SHALL add one output register stage between the array read and dout, making read latency 2 clocks.
REQ-021 The added stage SHALL advance only when en=1, clears on rst, and must not change write timing or read-first semantics.
REQ-022 With BLOCK_RAM_OUT_REG_EN undefined, read latency SHALL be exactly 1 clock, with no extra register.

Verification
REQ-023 Reset check: assert rst=1, en=1 for 2 edges with dout previously non-zero -> dout=0 after the first rst edge.
REQ-024 Write sequence: with en=1, rst=0, write 55<-23, 47<-1, 147<-1256 on consecutive edges, then read 55, 47, 147 on consecutive edges -> dout = 23, 1, 1256 each one edge after address is applied (two edges with OUT_REG).
REQ-025 Read unwritten address: read 46 -> dout=0, and di=126 presented with we=0 SHALL leave mem[55] at 23.
REQ-026 Read-during-write: mem[55]=23, write 55<-99 -> dout=23 on that edge, then read 55 -> dout=99.
REQ-027 Enable and alias check: en=0 with we=1, addr=47, di=5 -> mem[47] stays 1 and dout holds; then en=1 read addr 1024+147 -> dout=1256.
REQ-028 Reset mid-operation: rst=1 with we=1, addr=55, di=7 -> dout=0, and a later read of 55 returns the prior value, not 7.
